// File: rtl/riscv_id_ex_stage.sv
// -----------------------------------------------------------------------------
// riscv_id_ex_stage
//   ID/EX pipeline register for a 64-bit RISC-V core.
//   - Captures the decoded ID fields and control bits on each rising clock edge.
//   - Turns aluop/funct3/funct7b5 into the 4-bit ALU control code at load time.
//   - Forwards results from EX/MEM and MEM/WB into the ALU operands and store data.
//   - Raises load_use_stall and inserts a bubble when a load in EX feeds ID.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   id_*                  decoded instruction fields and control bits from ID
//   ex_hold               downstream stall: the stage keeps its contents
//   flush                 squash: a bubble is loaded (wins over ex_hold)
//   exmem_*, memwb_*      writeback sources used for forwarding
//   ex_valid, alu_ctl     registered valid flag and ALU control code
//   alu_a, alu_b          forwarded ALU operands (combinational)
//   ex_store_data         forwarded rs2 value for stores (combinational)
//   ex_rd, ex_<ctl>       registered destination register and control bits
//   load_use_stall        ID/IF must stall this cycle (combinational)
// -----------------------------------------------------------------------------
module riscv_id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RA   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA-1:0]   id_rs1,
  input  logic [RA-1:0]   id_rs2,
  input  logic [RA-1:0]   id_rd,
  input  logic [1:0]      id_aluop,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_alusrc,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            id_branch,
  input  logic            ex_hold,
  input  logic            flush,
  input  logic            exmem_regwrite,
  input  logic [RA-1:0]   exmem_rd,
  input  logic [XLEN-1:0] exmem_aluout,
  input  logic            memwb_regwrite,
  input  logic [RA-1:0]   memwb_rd,
  input  logic [XLEN-1:0] memwb_wdata,
  output logic            ex_valid,
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA-1:0]   ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_branch,
  output logic            load_use_stall
);

  typedef struct packed {
    logic            valid;
    logic [3:0]      ctl;
    logic [RA-1:0]   rs1;
    logic [RA-1:0]   rs2;
    logic [RA-1:0]   rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alusrc;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            branch;
  } stage_t;

  // Empty slot: everything zero, ALU control parked at the "invalid" code 15.
  function automatic stage_t bubble_f();
    stage_t b;
    b     = '0;
    b.ctl = 4'd15;
    return b;
  endfunction

  // funct3 -> ALU code shared by R-type and I-type; unsupported ops map to 15.
  function automatic logic [3:0] funct3_ctl_f(input logic [2:0] f3);
    logic [3:0] c;
    case (f3)
      3'b000:  c = 4'd2;
      3'b111:  c = 4'd0;
      3'b110:  c = 4'd1;
      3'b010:  c = 4'd7;
      default: c = 4'd15;
    endcase
    return c;
  endfunction

  // Full ALU control decode; funct7b5 only selects SUB for R-type funct3 000.
  function automatic logic [3:0] alu_ctl_f(input logic [1:0] op,
                                           input logic [2:0] f3,
                                           input logic       f7b5);
    logic [3:0] c;
    case (op)
      2'b00:   c = 4'd2;
      2'b01:   c = 4'd6;
      2'b10:   c = ((f3 == 3'b000) && f7b5) ? 4'd6 : funct3_ctl_f(f3);
      2'b11:   c = funct3_ctl_f(f3);
      default: c = 4'd15;
    endcase
    return c;
  endfunction

  stage_t          stage_r;
  stage_t          stage_nxt_s;
  logic            load_use_s;
  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;

  // Load-use hazard: a load in EX whose rd is read by the instruction in ID.
  // rs2 is compared even for I-type, which can only over-stall.
  always_comb begin
    load_use_s = 1'b0;
    if (stage_r.valid && stage_r.memread && (stage_r.rd != {RA{1'b0}}) && id_valid &&
        ((id_rs1 == stage_r.rd) || (id_rs2 == stage_r.rd))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next stage contents: flush > hold > bubble (stall or no instruction) > load.
  always_comb begin
    stage_nxt_s = stage_r;
    if (flush) begin
      stage_nxt_s = bubble_f();
    end else if (ex_hold) begin
      stage_nxt_s = stage_r;
    end else if (load_use_s || !id_valid) begin
      stage_nxt_s = bubble_f();
    end else begin
      stage_nxt_s.valid    = 1'b1;
      stage_nxt_s.ctl      = alu_ctl_f(id_aluop, id_funct3, id_funct7b5);
      stage_nxt_s.rs1      = id_rs1;
      stage_nxt_s.rs2      = id_rs2;
      stage_nxt_s.rd       = id_rd;
      stage_nxt_s.rs1_data = id_rs1_data;
      stage_nxt_s.rs2_data = id_rs2_data;
      stage_nxt_s.imm      = id_imm;
      stage_nxt_s.alusrc   = id_alusrc;
      stage_nxt_s.regwrite = id_regwrite;
      stage_nxt_s.memread  = id_memread;
      stage_nxt_s.memwrite = id_memwrite;
      stage_nxt_s.memtoreg = id_memtoreg;
      stage_nxt_s.branch   = id_branch;
    end
  end

  // Stage register; reset overrides flush and hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_r <= bubble_f();
    end else begin
      stage_r <= stage_nxt_s;
    end
  end

  // Operand forwarding for rs1; the younger EX/MEM result wins, x0 never forwards.
  always_comb begin
    fwd_rs1_s = stage_r.rs1_data;
    if (exmem_regwrite && (exmem_rd != {RA{1'b0}}) && (exmem_rd == stage_r.rs1)) begin
      fwd_rs1_s = exmem_aluout;
    end else if (memwb_regwrite && (memwb_rd != {RA{1'b0}}) && (memwb_rd == stage_r.rs1)) begin
      fwd_rs1_s = memwb_wdata;
    end else begin
      fwd_rs1_s = stage_r.rs1_data;
    end
  end

  // Operand forwarding for rs2, independent of rs1.
  always_comb begin
    fwd_rs2_s = stage_r.rs2_data;
    if (exmem_regwrite && (exmem_rd != {RA{1'b0}}) && (exmem_rd == stage_r.rs2)) begin
      fwd_rs2_s = exmem_aluout;
    end else if (memwb_regwrite && (memwb_rd != {RA{1'b0}}) && (memwb_rd == stage_r.rs2)) begin
      fwd_rs2_s = memwb_wdata;
    end else begin
      fwd_rs2_s = stage_r.rs2_data;
    end
  end

  assign alu_a          = fwd_rs1_s;
  assign alu_b          = stage_r.alusrc ? stage_r.imm : fwd_rs2_s;
  assign ex_store_data  = fwd_rs2_s;
  assign ex_valid       = stage_r.valid;
  assign alu_ctl        = stage_r.ctl;
  assign ex_rd          = stage_r.rd;
  assign ex_regwrite    = stage_r.regwrite;
  assign ex_memread     = stage_r.memread;
  assign ex_memwrite    = stage_r.memwrite;
  assign ex_memtoreg    = stage_r.memtoreg;
  assign ex_branch      = stage_r.branch;
  assign load_use_stall = load_use_s;

endmodule
